// File: rtl/msk_present_sbox_layer_ctrl.sv
// Serial sequencer that streams a d-share masked PRESENT state, one nibble per cycle, through one pipelined masked S-box.
// Optional build macro PRESENT_SBL_ZEROIZE_EN clears the state buffer and the rnd2 register on the output handshake.
module msk_present_sbox_layer_ctrl #(
  parameter int d      = 4,
  parameter int SB_LAT = 2,
  parameter int RND_W  = 12
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [64*d-1:0]      in_state,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [64*d-1:0]      out_state,
  input  logic                 rnd_valid,
  output logic                 rnd_ready,
  input  logic [2*RND_W-1:0]   rnd_in,
  output logic [4*d-1:0]       sb_in,
  output logic [RND_W-1:0]     sb_rnd1,
  output logic [RND_W-1:0]     sb_rnd2,
  input  logic [4*d-1:0]       sb_out,
  output logic                 busy
);
  localparam int NW = 4*d;
  localparam int SW = 64*d;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t            r_state;
  logic [SW-1:0]     r_buf;
  logic [4:0]        r_issue_cnt;
  logic [4:0]        r_ret_cnt;
  logic [SB_LAT-1:0] r_vld;
  logic [3:0]        r_idx [SB_LAT];
  logic [RND_W-1:0]  r_rnd2;
  logic              r_in_ready;
  logic              r_out_valid;
  logic              r_busy;

  logic              w_issue;
  logic              w_wb;
  logic [3:0]        w_wb_idx;
  logic [NW-1:0]     w_nib;

  always_comb w_issue = (r_state == S_RUN) && rnd_valid && (r_issue_cnt < 5'd16);

  assign w_wb     = r_vld[SB_LAT-1];
  assign w_wb_idx = r_idx[SB_LAT-1];

  always_comb begin
    w_nib = '0;
    for (int k = 0; k < 16; k++)
      if (r_issue_cnt[3:0] == 4'(k)) w_nib = r_buf[NW*k +: NW];
  end

  // Issue-side outputs are zero in every non-issue cycle so the S-box never sees stale shares.
  assign rnd_ready = w_issue;
  assign sb_in     = w_issue ? w_nib : '0;
  assign sb_rnd1   = w_issue ? rnd_in[RND_W-1:0] : '0;
  assign sb_rnd2   = r_rnd2;
  assign out_state = r_buf;
  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_buf       <= '0;
      r_issue_cnt <= '0;
      r_ret_cnt   <= '0;
      r_vld       <= '0;
      for (int i = 0; i < SB_LAT; i++) r_idx[i] <= '0;
      r_rnd2      <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      // Token pipe mirrors the S-box latency; the exiting index selects the write-back nibble.
      r_vld[0] <= w_issue;
      r_idx[0] <= r_issue_cnt[3:0];
      for (int i = 1; i < SB_LAT; i++) begin
        r_vld[i] <= r_vld[i-1];
        r_idx[i] <= r_idx[i-1];
      end
      r_rnd2 <= w_issue ? rnd_in[2*RND_W-1:RND_W] : '0;

      if (w_wb) begin
        for (int k = 0; k < 16; k++)
          if (w_wb_idx == 4'(k)) r_buf[NW*k +: NW] <= sb_out;
        if (r_ret_cnt < 5'd16) r_ret_cnt <= r_ret_cnt + 5'd1;
      end

      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_buf       <= in_state;
            r_issue_cnt <= '0;
            r_ret_cnt   <= '0;
            r_state     <= S_RUN;
            r_in_ready  <= 1'b0;
            r_busy      <= 1'b1;
          end
        end
        S_RUN: begin
          if (w_issue) begin
            r_issue_cnt <= r_issue_cnt + 5'd1;
            if (r_issue_cnt == 5'd15) r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if ((r_ret_cnt == 5'd16) || (w_wb && (r_ret_cnt == 5'd15))) begin
            r_state     <= S_DONE;
            r_busy      <= 1'b0;
            r_out_valid <= 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
`ifdef PRESENT_SBL_ZEROIZE_EN
            r_buf       <= '0;
            r_rnd2      <= '0;
`endif
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_msk_present_sbox_layer_ctrl.sv
// Bench for msk_present_sbox_layer_ctrl: behavioural masked S-box model plus an unmasked PRESENT reference.
module tb_msk_present_sbox_layer_ctrl;
  localparam int D      = 4;
  localparam int SB_LAT = 2;
  localparam int RND_W  = 12;
  localparam int SW     = 64*D;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               in_valid;
  logic               in_ready;
  logic [SW-1:0]      in_state;
  logic               out_valid;
  logic               out_ready;
  logic [SW-1:0]      out_state;
  logic               rnd_valid;
  logic               rnd_ready;
  logic [2*RND_W-1:0] rnd_in;
  logic [4*D-1:0]     sb_in;
  logic [RND_W-1:0]   sb_rnd1;
  logic [RND_W-1:0]   sb_rnd2;
  logic [4*D-1:0]     sb_out;
  logic               busy;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [SW-1:0] cur_sh;
  logic [63:0]   idle_val;
  logic          idle_zero;

  msk_present_sbox_layer_ctrl #(.d(D), .SB_LAT(SB_LAT), .RND_W(RND_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_state(in_state),
    .out_valid(out_valid), .out_ready(out_ready), .out_state(out_state),
    .rnd_valid(rnd_valid), .rnd_ready(rnd_ready), .rnd_in(rnd_in),
    .sb_in(sb_in), .sb_rnd1(sb_rnd1), .sb_rnd2(sb_rnd2), .sb_out(sb_out), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [3:0] present_s(input logic [3:0] x);
    logic [63:0] t;
    t = 64'h21748FE3DA09B65C;
    return t[{x, 2'b00} +: 4];
  endfunction

  function automatic logic [63:0] sbox_layer(input logic [63:0] v);
    logic [63:0] r;
    for (int k = 0; k < 16; k++) r[4*k +: 4] = present_s(v[4*k +: 4]);
    return r;
  endfunction

  function automatic logic [D-1:0] share_bit(input logic b);
    logic [D-1:0] m;
    m = D'($urandom);
    m[0] = b ^ (^m[D-1:1]);
    return m;
  endfunction

  function automatic logic [SW-1:0] share_state(input logic [63:0] v);
    logic [SW-1:0] s;
    for (int j = 0; j < 64; j++) s[D*j +: D] = share_bit(v[j]);
    return s;
  endfunction

  function automatic logic [63:0] unshare(input logic [SW-1:0] s);
    logic [63:0] r;
    for (int j = 0; j < 64; j++) r[j] = ^s[D*j +: D];
    return r;
  endfunction

  function automatic logic [4*D-1:0] sbox_shared(input logic [4*D-1:0] x);
    logic [3:0]     n;
    logic [3:0]     y;
    logic [4*D-1:0] r;
    for (int b = 0; b < 4; b++) n[b] = ^x[D*b +: D];
    y = present_s(n);
    for (int b = 0; b < 4; b++) r[D*b +: D] = share_bit(y[b]);
    return r;
  endfunction

  // External masked S-box: fixed latency, no enable, fresh output sharing.
  logic [4*D-1:0] sbm [SB_LAT];
  always @(posedge clk) begin
    sbm[0] <= sbox_shared(sb_in);
    for (int i = 1; i < SB_LAT; i++) sbm[i] <= sbm[i-1];
  end
  assign sb_out = sbm[SB_LAT-1];

  task automatic check(input string tag, input logic [SW-1:0] obs, input logic [SW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle_checks();
    check("idle_in_ready", SW'(in_ready), SW'(1));
    check("idle_out_valid", SW'(out_valid), SW'(0));
    check("idle_busy", SW'(busy), SW'(0));
    check("idle_rnd_ready", SW'(rnd_ready), SW'(0));
    check("idle_sb_in", SW'(sb_in), SW'(0));
    if (idle_zero) check("idle_buf_zero", out_state, SW'(0));
    else check("idle_buf_retained", SW'(unshare(out_state)), SW'(idle_val));
  endtask

  // mode 0: rnd always valid; 1: pattern 1,0,0; 2: random.
  task automatic do_run(input logic [63:0] v, input logic [63:0] expv, input int mode,
                        input int bp, input bit b2b);
    int t0, issued, gaps, last_issue, pulses, budget;
    bit exp_iss, prev_issue;
    logic [RND_W-1:0] prev_hi;
    logic [SW-1:0] held;
    @(negedge clk);
    out_ready = b2b;
    cur_sh    = share_state(v);
    in_state  = cur_sh;
    in_valid  = 1'b1;
    rnd_valid = 1'b1;
    rnd_in    = (2*RND_W)'($urandom);
    #1;
    idle_checks();
    t0 = cyc;
    issued = 0; gaps = 0; last_issue = 0; pulses = 0; budget = 0; prev_issue = 0; prev_hi = '0;
    while (budget < 400) begin
      @(negedge clk);
      budget++;
      in_valid = b2b;
      case (mode)
        0:       rnd_valid = 1'b1;
        1:       rnd_valid = (((cyc - t0 - 1) % 3) == 0);
        default: rnd_valid = 1'($urandom_range(0, 1));
      endcase
      rnd_in = (2*RND_W)'($urandom);
      #1;
      if (out_valid) break;
      exp_iss = rnd_valid && (issued < 16);
      check("run_rnd_ready", SW'(rnd_ready), SW'(exp_iss));
      check("run_sb_in", SW'(sb_in), exp_iss ? SW'(cur_sh[4*D*issued +: 4*D]) : SW'(0));
      if (exp_iss) check("run_sb_rnd1", SW'(sb_rnd1), SW'(rnd_in[RND_W-1:0]));
      if (prev_issue) check("run_sb_rnd2", SW'(sb_rnd2), SW'(prev_hi));
      check("run_busy", SW'(busy), SW'(1));
      check("run_in_ready", SW'(in_ready), SW'(0));
      if (rnd_ready) pulses++;
      prev_issue = exp_iss;
      prev_hi    = rnd_in[2*RND_W-1:RND_W];
      if (exp_iss) begin
        issued++;
        if (issued == 16) last_issue = cyc;
      end else if (issued < 16) gaps++;
    end
    if (!out_valid) begin
      check("timeout_out_valid", SW'(out_valid), SW'(1));
      return;
    end
    check("out_valid_cycle", SW'(cyc), SW'(t0 + 17 + SB_LAT + gaps));
    check("out_after_last_issue", SW'(cyc), SW'(last_issue + 1 + SB_LAT));
    check("rnd_ready_pulses", SW'(pulses), SW'(16));
    check("result", SW'(unshare(out_state)), SW'(expv));
    check("done_in_ready", SW'(in_ready), SW'(0));
    check("done_busy", SW'(busy), SW'(0));
    check("done_rnd_ready", SW'(rnd_ready), SW'(0));
    held = out_state;
    if (!b2b) begin
      for (int i = 0; i < bp; i++) begin
        @(negedge clk);
        out_ready = 1'b0;
        rnd_valid = 1'($urandom_range(0, 1));
        in_valid  = 1'($urandom_range(0, 1));
        #1;
        check("bp_out_valid", SW'(out_valid), SW'(1));
        check("bp_out_state", out_state, held);
        check("bp_in_ready", SW'(in_ready), SW'(0));
      end
      @(negedge clk);
      out_ready = 1'b1;
      in_valid  = 1'b0;
      #1;
      check("hs_out_valid", SW'(out_valid), SW'(1));
      check("hs_out_state", out_state, held);
    end
    idle_val = expv;
`ifdef PRESENT_SBL_ZEROIZE_EN
    idle_zero = 1'b1;
`else
    idle_zero = 1'b0;
`endif
  endtask

  task automatic mid_reset(input logic [63:0] v);
    @(negedge clk);
    out_ready = 1'b0;
    cur_sh    = share_state(v);
    in_state  = cur_sh;
    in_valid  = 1'b1;
    rnd_valid = 1'b0;
    #1;
    idle_checks();
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      in_valid  = 1'b0;
      rnd_valid = 1'b1;
      rnd_in    = (2*RND_W)'($urandom);
      #1;
      check("mr_rnd_ready", SW'(rnd_ready), SW'(1));
      check("mr_sb_in", SW'(sb_in), SW'(cur_sh[4*D*i +: 4*D]));
    end
    @(negedge clk);
    rnd_valid = 1'b1;
    rst_n     = 1'b0;
    #1;
    check("mr_in_ready", SW'(in_ready), SW'(1));
    check("mr_busy", SW'(busy), SW'(0));
    check("mr_out_valid", SW'(out_valid), SW'(0));
    check("mr_buf", out_state, SW'(0));
    check("mr_rnd_ready", SW'(rnd_ready), SW'(0));
    check("mr_sb_rnd2", SW'(sb_rnd2), SW'(0));
    @(negedge clk);
    rst_n     = 1'b1;
    rnd_valid = 1'b0;
    idle_zero = 1'b1;
  endtask

  initial begin
    logic [63:0] ra, rb, rc;
    rst_n = 1'b0; in_valid = 1'b0; in_state = '0; out_ready = 1'b0;
    rnd_valid = 1'b0; rnd_in = '0;
    idle_zero = 1'b1; idle_val = '0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_in_ready", SW'(in_ready), SW'(1));
    check("rst_out_valid", SW'(out_valid), SW'(0));
    check("rst_busy", SW'(busy), SW'(0));
    check("rst_rnd_ready", SW'(rnd_ready), SW'(0));
    check("rst_sb_in", SW'(sb_in), SW'(0));
    check("rst_sb_rnd1", SW'(sb_rnd1), SW'(0));
    check("rst_sb_rnd2", SW'(sb_rnd2), SW'(0));
    check("rst_out_state", out_state, SW'(0));
    @(negedge clk);
    rst_n = 1'b1;

    do_run(64'h0123456789ABCDEF, 64'hC56B90AD3EF84712, 0, 0, 1'b0);
    do_run(64'h0123456789ABCDEF, 64'hC56B90AD3EF84712, 1, 0, 1'b0);
    ra = {$urandom, $urandom};
    do_run(ra, sbox_layer(ra), 0, 10, 1'b0);
    mid_reset({$urandom, $urandom});
    do_run(64'h0, 64'hCCCCCCCCCCCCCCCC, 2, 0, 1'b0);
    ra = {$urandom, $urandom};
    rb = {$urandom, $urandom};
    do_run(ra, sbox_layer(ra), 0, 0, 1'b1);
    do_run(rb, sbox_layer(rb), 2, 0, 1'b1);
    rc = {$urandom, $urandom};
    do_run(rc, sbox_layer(rc), 1, 3, 1'b0);

    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b0;
    rnd_valid = 1'b1;
    #1;
    idle_checks();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
